// File: rtl/hazard_pkg.sv
// Shared decode helpers, opcode constants and tracker entry layout for the RAW hazard unit.
package hazard_pkg;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    typedef struct packed {
        logic       v;
        logic [4:0] rd;
        logic       ld;
    } trk_entry_t;

    typedef enum logic {
        ST_RUN,
        ST_HOLD
    } stall_state_e;

    function automatic logic uses_rs1(input logic [6:0] op);
        return !(op == OP_LUI || op == OP_AUIPC || op == OP_JAL);
    endfunction

    function automatic logic uses_rs2(input logic [6:0] op);
        return ~op[2] & op[5] & (~op[6] | ~op[4]);
    endfunction

    function automatic logic writes_rd(input logic [6:0] op);
        return !(op == OP_STORE || op == OP_BRANCH);
    endfunction

    function automatic logic is_load(input logic [6:0] op);
        return op == OP_LOAD;
    endfunction

endpackage

// File: rtl/hazard_cmp.sv
// One tracker entry against one source register; x0 never produces a match.
module hazard_cmp (
    input  logic       v_i,
    input  logic [4:0] rd_i,
    input  logic [4:0] rs_i,
    input  logic       uses_i,
    output logic       match_o
);

    assign match_o = uses_i & (rs_i != '0) & v_i & (rd_i == rs_i);

endmodule

// File: rtl/hazard_scoreboard.sv
// RAW hazard scoreboard beside decode: DEPTH-entry destination tracker, stall and forward selects.
// Define HAZARD_FWD_EN to stall only on load-use and drive forwarding selects.
module hazard_scoreboard
    import hazard_pkg::*;
#(
    parameter int unsigned DEPTH = 3,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             id_valid,
    input  logic [6:0]       id_op,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic [4:0]       id_rd,
    input  logic             flush,
    output logic             stall,
    output logic [2:0]       fwd_rs1_sel,
    output logic [2:0]       fwd_rs2_sel,
    output logic [CNT_W-1:0] stall_cnt
);

    trk_entry_t       trk_q [DEPTH];
    trk_entry_t       trk_d [DEPTH];
    logic [DEPTH-1:0] m1;
    logic [DEPTH-1:0] m2;
    logic             use1;
    logic             use2;
    logic             hit;
    stall_state_e     state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign use1 = id_valid & uses_rs1(id_op);
    assign use2 = id_valid & uses_rs2(id_op);

    for (genvar k = 0; k < DEPTH; k++) begin : g_cmp
        hazard_cmp u_cmp_rs1 (
            .v_i    (trk_q[k].v),
            .rd_i   (trk_q[k].rd),
            .rs_i   (id_rs1),
            .uses_i (use1),
            .match_o(m1[k])
        );
        hazard_cmp u_cmp_rs2 (
            .v_i    (trk_q[k].v),
            .rd_i   (trk_q[k].rd),
            .rs_i   (id_rs2),
            .uses_i (use2),
            .match_o(m2[k])
        );
    end

`ifdef HAZARD_FWD_EN
    logic f1, f2;

    // Youngest match decides; a load still in EX cannot forward, so its select stays 0.
    always_comb begin
        hit         = (m1[0] | m2[0]) & trk_q[0].ld;
        fwd_rs1_sel = '0;
        fwd_rs2_sel = '0;
        f1          = 1'b0;
        f2          = 1'b0;
        for (int unsigned k = 0; k < DEPTH; k++) begin
            if (m1[k] && !f1) begin
                f1 = 1'b1;
                if (!(k == 0 && trk_q[0].ld)) fwd_rs1_sel = 3'(k + 1);
            end
            if (m2[k] && !f2) begin
                f2 = 1'b1;
                if (!(k == 0 && trk_q[0].ld)) fwd_rs2_sel = 3'(k + 1);
            end
        end
    end
`else
    // The oldest entry writes back this cycle and the regfile reads the new value.
    localparam logic [DEPTH-1:0] LIVE_MASK = {DEPTH{1'b1}} >> 1;

    always_comb begin
        hit         = |((m1 | m2) & LIVE_MASK);
        fwd_rs1_sel = '0;
        fwd_rs2_sel = '0;
    end
`endif

    assign stall     = id_valid & ~flush & hit;
    assign stall_cnt = cnt_q;

    always_comb begin
        trk_d[0] = '0;
        if (id_valid && writes_rd(id_op) && !stall && !flush) begin
            trk_d[0] = {1'b1, id_rd, is_load(id_op)};
        end
        for (int unsigned k = 1; k < DEPTH; k++) begin
            trk_d[k] = trk_q[k-1];
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_RUN:  if (stall)  state_d = ST_HOLD;
            ST_HOLD: if (!stall) state_d = ST_RUN;
            default: state_d = ST_RUN;
        endcase
        if (stall && cnt_q != '1) cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned k = 0; k < DEPTH; k++) begin
                trk_q[k] <= '0;
            end
            state_q <= ST_RUN;
            cnt_q   <= '0;
        end else begin
            for (int unsigned k = 0; k < DEPTH; k++) begin
                trk_q[k] <= trk_d[k];
            end
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed vector bench for hazard_scoreboard (DEPTH=3), plus a CNT_W=4 instance for saturation.
module tb_hazard_scoreboard;

    localparam logic [6:0] OPC_R    = 7'b0110011;
    localparam logic [6:0] OPC_I    = 7'b0010011;
    localparam logic [6:0] OPC_LD   = 7'b0000011;
    localparam logic [6:0] OPC_ST   = 7'b0100011;
    localparam logic [6:0] OPC_BR   = 7'b1100011;
    localparam logic [6:0] OPC_LUI  = 7'b0110111;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        id_valid;
    logic [6:0]  id_op;
    logic [4:0]  id_rs1, id_rs2, id_rd;
    logic        flush;
    logic        stall, stall4;
    logic [2:0]  sel1, sel2, sel1_4, sel2_4;
    logic [15:0] cnt;
    logic [3:0]  cnt4;

    int n_chk  = 0;
    int n_fail = 0;
    int exp_cnt = 0;

    always #5 clk = ~clk;

    hazard_scoreboard #(.DEPTH(3), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_op(id_op),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .flush(flush),
        .stall(stall), .fwd_rs1_sel(sel1), .fwd_rs2_sel(sel2), .stall_cnt(cnt)
    );

    hazard_scoreboard #(.DEPTH(3), .CNT_W(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_op(id_op),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .flush(flush),
        .stall(stall4), .fwd_rs1_sel(sel1_4), .fwd_rs2_sel(sel2_4), .stall_cnt(cnt4)
    );

    typedef struct {
        logic       valid;
        logic [6:0] op;
        logic [4:0] rs1, rs2, rd;
        logic       flush;
        logic       st;
        logic [2:0] s1, s2;
    } vec_t;

    vec_t tbl[$];

    // Expectations are given for both builds; the active one is picked here.
    function automatic vec_t mk(input logic v, input logic [6:0] op, input logic [4:0] rs1,
                                input logic [4:0] rs2, input logic [4:0] rd, input logic fl,
                                input logic st_nf, input logic st_fw,
                                input logic [2:0] s1_fw, input logic [2:0] s2_fw);
        vec_t r;
        r.valid = v; r.op = op; r.rs1 = rs1; r.rs2 = rs2; r.rd = rd; r.flush = fl;
`ifdef HAZARD_FWD_EN
        r.st = st_fw; r.s1 = s1_fw; r.s2 = s2_fw;
`else
        r.st = st_nf; r.s1 = s1_fw & 3'b000; r.s2 = s2_fw & 3'b000;
`endif
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step(input vec_t v, input string tag);
        @(posedge clk);
        #1;
        id_valid = v.valid; id_op = v.op; id_rs1 = v.rs1; id_rs2 = v.rs2;
        id_rd = v.rd; flush = v.flush;
        @(negedge clk);
        chk({tag, ".stall"}, 32'(stall), 32'(v.st));
        chk({tag, ".sel1"},  32'(sel1),  32'(v.s1));
        chk({tag, ".sel2"},  32'(sel2),  32'(v.s2));
        chk({tag, ".cnt"},   32'(cnt),   32'(exp_cnt));
        chk({tag, ".cnt4"},  32'(cnt4),  32'((exp_cnt > 15) ? 15 : exp_cnt));
        chk({tag, ".stall4"}, 32'(stall4), 32'(v.st));
        if (v.st) exp_cnt++;
    endtask

    initial begin
        vec_t idle, b_lw, b_sw1, b_sw2, b_sw3, sw_clr;

        idle  = mk(0, OPC_R, 0, 0, 0, 0, 0, 0, 0, 0);
        b_lw  = mk(1, OPC_LD, 1, 0, 5, 0, 0, 0, 0, 0);
        b_sw1 = mk(1, OPC_ST, 2, 5, 0, 0, 1, 1, 0, 0);
        b_sw2 = mk(1, OPC_ST, 2, 5, 0, 0, 1, 0, 0, 2);
        b_sw3 = mk(1, OPC_ST, 2, 5, 0, 0, 0, 0, 0, 3);
        sw_clr = mk(1, OPC_ST, 2, 5, 0, 0, 0, 0, 0, 0);

        // add x5 then dependent add x6,x5,x1 held in decode
        tbl.push_back(idle);
        tbl.push_back(mk(1, OPC_R, 1, 2, 5, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, OPC_R, 5, 1, 6, 0, 1, 0, 1, 0));
        tbl.push_back(mk(1, OPC_R, 5, 1, 6, 0, 1, 0, 2, 0));
        tbl.push_back(mk(1, OPC_R, 5, 1, 6, 0, 0, 0, 3, 0));
        tbl.push_back(mk(0, OPC_R, 6, 6, 0, 0, 0, 0, 0, 0));
        tbl.push_back(idle);
        tbl.push_back(idle);
        // lw x5 then sw x5,0(x2)
        tbl.push_back(b_lw);
        tbl.push_back(b_sw1);
        tbl.push_back(b_sw2);
        tbl.push_back(b_sw3);
        tbl.push_back(idle);
        tbl.push_back(idle);
        tbl.push_back(idle);
        // x0 and unused-source fields never match
        tbl.push_back(mk(1, OPC_I, 1, 5, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, OPC_R, 0, 0, 1, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, OPC_I, 2, 1, 9, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, OPC_LUI, 1, 9, 3, 0, 0, 0, 0, 0));
        tbl.push_back(idle);
        tbl.push_back(idle);
        tbl.push_back(idle);
        // flush beats stall and leaves a bubble instead of x7
        tbl.push_back(b_lw);
        tbl.push_back(mk(1, OPC_BR, 5, 5, 0, 1, 0, 0, 0, 0));
        tbl.push_back(mk(1, OPC_R, 5, 5, 7, 1, 0, 0, 2, 2));
        tbl.push_back(mk(1, OPC_R, 7, 0, 8, 0, 0, 0, 0, 0));
        tbl.push_back(idle);
        tbl.push_back(idle);
        tbl.push_back(idle);

        rst_n = 1'b0;
        id_valid = 1'b0; id_op = OPC_R; id_rs1 = '0; id_rs2 = '0; id_rd = '0; flush = 1'b0;
        #3;
        chk("reset.stall", 32'(stall), 0);
        chk("reset.sel1",  32'(sel1), 0);
        chk("reset.sel2",  32'(sel2), 0);
        chk("reset.cnt",   32'(cnt), 0);
        chk("reset.cnt4",  32'(cnt4), 0);
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;

        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i], $sformatf("vec%0d", i));
        end

        for (int i = 0; i < 20; i++) begin
            step(b_lw,  $sformatf("sat%0d.lw", i));
            step(b_sw1, $sformatf("sat%0d.sw1", i));
            step(b_sw2, $sformatf("sat%0d.sw2", i));
            step(b_sw3, $sformatf("sat%0d.sw3", i));
        end
        @(negedge clk);
        chk("sat.cnt16", 32'(cnt), 32'(exp_cnt));
        chk("sat.cnt4",  32'(cnt4), 15);

        // asynchronous reset in the middle of a stall
        step(b_lw,  "rst.lw");
        step(b_sw1, "rst.sw");
        #1 rst_n = 1'b0;
        #1;
        exp_cnt = 0;
        chk("rst_mid.stall", 32'(stall), 0);
        chk("rst_mid.sel1",  32'(sel1), 0);
        chk("rst_mid.sel2",  32'(sel2), 0);
        chk("rst_mid.cnt",   32'(cnt), 0);
        chk("rst_mid.cnt4",  32'(cnt4), 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        step(sw_clr, "rst.after");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
